// File: rtl/hash_requestor_if.sv
// Memory-side channels of the hash requestor: read requests, read responses
// and line writes. The requestor is the master; the memory/host side is the slave.
interface hash_requestor_if;
  logic         rd_valid;
  logic [41:0]  rd_addr;
  logic [1:0]   rd_len;
  logic [15:0]  rd_tag;
  logic         rd_almfull;

  logic         rsp_valid;
  logic [15:0]  rsp_tag;
  logic [1:0]   rsp_clnum;
  logic [511:0] rsp_data;

  logic         wr_valid;
  logic [41:0]  wr_addr;
  logic [511:0] wr_data;
  logic         wr_almfull;

  modport master (
    output rd_valid, rd_addr, rd_len, rd_tag,
    input  rd_almfull,
    input  rsp_valid, rsp_tag, rsp_clnum, rsp_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_almfull
  );

  modport slave (
    input  rd_valid, rd_addr, rd_len, rd_tag,
    output rd_almfull,
    output rsp_valid, rsp_tag, rsp_clnum, rsp_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_almfull
  );
endinterface

// File: rtl/hash_requestor.sv
// Streams a source buffer through a reorder buffer into a hash core, then
// writes the final digest and a completion status line.
module hash_requestor #(
  parameter int CL_PER_REQ       = 2,
  parameter int BUF_DEPTH        = 8,
  parameter int LINES_PER_DIGEST = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [41:0]           src_addr,
  input  logic [31:0]           src_lines,
  input  logic [41:0]           dst_addr,
  input  logic [41:0]           dsm_addr,
  hash_requestor_if.master      bus,
  output logic [511:0]          block,
  output logic                  block_valid,
  input  logic                  block_ready,
  input  logic [511:0]          digest,
  input  logic                  digest_valid,
  output logic                  busy
);

  localparam int          SLOT_W  = $clog2(BUF_DEPTH);
  localparam logic [31:0] CL_U    = 32'(CL_PER_REQ);
  localparam logic [31:0] DEPTH_U = 32'(BUF_DEPTH);
  localparam logic [31:0] LPD_U   = 32'(LINES_PER_DIGEST);
  localparam logic [31:0] GRAN_U  = 32'(CL_PER_REQ * LINES_PER_DIGEST);

  typedef enum logic [1:0] {IDLE, RUN, WR_DIGEST, WR_DSM} state_t;

  state_t         state_reg, state_next;
  logic [41:0]    src_addr_reg, src_addr_next;
  logic [31:0]    src_lines_reg, src_lines_next;
  logic [41:0]    dst_addr_reg, dst_addr_next;
  logic [41:0]    dsm_addr_reg, dsm_addr_next;
  logic [31:0]    digests_needed_reg, digests_needed_next;
  logic [1:0]     status_reg, status_next;
  logic [31:0]    issued_reg, issued_next;
  logic [31:0]    drained_reg, drained_next;
  logic [31:0]    digest_cnt_reg, digest_cnt_next;
  logic [511:0]   last_digest_reg, last_digest_next;
  logic           digest_valid_d_reg;
  logic           block_valid_reg, block_valid_next;
  logic [511:0]   block_reg;
  logic           rd_valid_reg, rd_valid_next;
  logic [41:0]    rd_addr_reg, rd_addr_next;
  logic [1:0]     rd_len_reg, rd_len_next;
  logic [15:0]    rd_tag_reg, rd_tag_next;
  logic           wr_valid_reg, wr_valid_next;
  logic [41:0]    wr_addr_reg, wr_addr_next;
  logic [511:0]   wr_data_reg, wr_data_next;

  logic [511:0]         slot_mem [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] slot_valid_reg;

  logic              job_bad;
  logic [SLOT_W-1:0] head;
  logic [SLOT_W-1:0] fill_slot;
  logic              drain_fire;
  logic              fill_fire;
  logic              issue_ok;
  logic              digest_rise;
  logic [31:0]       drained_upd;
  logic [31:0]       in_flight;

  assign job_bad     = (src_lines == 32'd0) || ((src_lines % GRAN_U) != 32'd0);
  assign head        = drained_reg[SLOT_W-1:0];
  assign fill_slot   = SLOT_W'(bus.rsp_tag + 16'(bus.rsp_clnum));
  // Responses outside RUN belong to an abandoned job and are dropped.
  assign fill_fire   = bus.rsp_valid && (state_reg == RUN);
  assign drain_fire  = (state_reg == RUN) && slot_valid_reg[head] &&
                       (!block_valid_reg || block_ready);
  assign drained_upd = drained_reg + (drain_fire ? 32'd1 : 32'd0);
  assign in_flight   = issued_reg - drained_upd;
  assign issue_ok    = (state_reg == RUN) && !bus.rd_almfull &&
                       (issued_reg < src_lines_reg) && (in_flight + CL_U <= DEPTH_U);
  assign digest_rise = digest_valid && !digest_valid_d_reg;

  always_comb begin
    state_next          = state_reg;
    src_addr_next       = src_addr_reg;
    src_lines_next      = src_lines_reg;
    dst_addr_next       = dst_addr_reg;
    dsm_addr_next       = dsm_addr_reg;
    digests_needed_next = digests_needed_reg;
    status_next         = status_reg;
    issued_next         = issued_reg;
    drained_next        = drained_reg;
    digest_cnt_next     = digest_cnt_reg;
    last_digest_next    = last_digest_reg;
    rd_valid_next       = 1'b0;
    rd_addr_next        = rd_addr_reg;
    rd_len_next         = rd_len_reg;
    rd_tag_next         = rd_tag_reg;
    wr_valid_next       = 1'b0;
    wr_addr_next        = wr_addr_reg;
    wr_data_next        = wr_data_reg;

    if (drain_fire)       block_valid_next = 1'b1;
    else if (block_ready) block_valid_next = 1'b0;
    else                  block_valid_next = block_valid_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_addr_next       = src_addr;
          src_lines_next      = src_lines;
          dst_addr_next       = dst_addr;
          dsm_addr_next       = dsm_addr;
          digests_needed_next = src_lines / LPD_U;
          issued_next         = 32'd0;
          drained_next        = 32'd0;
          digest_cnt_next     = 32'd0;
          if (job_bad) begin
            status_next = 2'd2;
            state_next  = WR_DSM;
          end else begin
            status_next = 2'd1;
            state_next  = RUN;
          end
        end
      end
      RUN: begin
        drained_next = drained_upd;
        if (issue_ok) begin
          rd_valid_next = 1'b1;
          rd_addr_next  = src_addr_reg + 42'(issued_reg);
          rd_len_next   = 2'(CL_PER_REQ - 1);
          rd_tag_next   = 16'(issued_reg[SLOT_W-1:0]);
          issued_next   = issued_reg + CL_U;
        end
        if (digest_rise) begin
          digest_cnt_next  = digest_cnt_reg + 32'd1;
          last_digest_next = digest;
        end
        if ((drained_reg == src_lines_reg) && (digest_cnt_reg == digests_needed_reg))
          state_next = WR_DIGEST;
      end
      WR_DIGEST: begin
        if (!bus.wr_almfull) begin
          wr_valid_next = 1'b1;
          wr_addr_next  = dst_addr_reg;
          wr_data_next  = last_digest_reg;
          state_next    = WR_DSM;
        end
      end
      WR_DSM: begin
        if (!bus.wr_almfull) begin
          wr_valid_next = 1'b1;
          wr_addr_next  = dsm_addr_reg + 42'd1;
          wr_data_next  = {510'd0, status_reg};
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      src_addr_reg       <= '0;
      src_lines_reg      <= '0;
      dst_addr_reg       <= '0;
      dsm_addr_reg       <= '0;
      digests_needed_reg <= '0;
      status_reg         <= '0;
      issued_reg         <= '0;
      drained_reg        <= '0;
      digest_cnt_reg     <= '0;
      last_digest_reg    <= '0;
      digest_valid_d_reg <= 1'b0;
      block_valid_reg    <= 1'b0;
      rd_valid_reg       <= 1'b0;
      rd_addr_reg        <= '0;
      rd_len_reg         <= '0;
      rd_tag_reg         <= '0;
      wr_valid_reg       <= 1'b0;
      wr_addr_reg        <= '0;
      wr_data_reg        <= '0;
    end else begin
      state_reg          <= state_next;
      src_addr_reg       <= src_addr_next;
      src_lines_reg      <= src_lines_next;
      dst_addr_reg       <= dst_addr_next;
      dsm_addr_reg       <= dsm_addr_next;
      digests_needed_reg <= digests_needed_next;
      status_reg         <= status_next;
      issued_reg         <= issued_next;
      drained_reg        <= drained_next;
      digest_cnt_reg     <= digest_cnt_next;
      last_digest_reg    <= last_digest_next;
      digest_valid_d_reg <= digest_valid;
      block_valid_reg    <= block_valid_next;
      rd_valid_reg       <= rd_valid_next;
      rd_addr_reg        <= rd_addr_next;
      rd_len_reg         <= rd_len_next;
      rd_tag_reg         <= rd_tag_next;
      wr_valid_reg       <= wr_valid_next;
      wr_addr_reg        <= wr_addr_next;
      wr_data_reg        <= wr_data_next;
    end
  end

  // Reorder storage: written by responses, read only into the output register.
  always_ff @(posedge clk) begin
    if (fill_fire) slot_mem[fill_slot] <= bus.rsp_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        block_reg <= '0;
    else if (drain_fire) block_reg <= slot_mem[head];
  end

  // A fill and a drain never target the same slot, so each bit sees at most one.
  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        slot_valid_reg[gi] <= 1'b0;
      else if (fill_fire && (fill_slot == SLOT_W'(gi)))
        slot_valid_reg[gi] <= 1'b1;
      else if (drain_fire && (head == SLOT_W'(gi)))
        slot_valid_reg[gi] <= 1'b0;
    end
  end

  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_addr  = rd_addr_reg;
  assign bus.rd_len   = rd_len_reg;
  assign bus.rd_tag   = rd_tag_reg;
  assign bus.wr_valid = wr_valid_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign block        = block_reg;
  assign block_valid  = block_valid_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_hash_requestor.sv
// Directed bench for hash_requestor: a host model answers reads, a hash-core
// model consumes blocks and pulses digests, and each step is checked inline.
module tb_hash_requestor;
  localparam int CL  = 2;
  localparam int BD  = 8;
  localparam int LPD = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [41:0]  src_addr, dst_addr, dsm_addr;
  logic [31:0]  src_lines;
  logic [511:0] block;
  logic         block_valid, block_ready;
  logic [511:0] digest;
  logic         digest_valid;
  logic         busy;

  hash_requestor_if bus ();

  hash_requestor #(.CL_PER_REQ(CL), .BUF_DEPTH(BD), .LINES_PER_DIGEST(LPD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .src_addr     (src_addr),
    .src_lines    (src_lines),
    .dst_addr     (dst_addr),
    .dsm_addr     (dsm_addr),
    .bus          (bus),
    .block        (block),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int served = 0;
  int rd_viol = 0;
  int wr_viol = 0;

  logic [41:0]  rd_addr_q [$];
  logic [15:0]  rd_tag_q  [$];
  logic [41:0]  wr_addr_q [$];
  logic [511:0] wr_data_q [$];
  logic [511:0] blk_q     [$];

  function automatic logic [511:0] line_pat(input logic [41:0] a);
    return {16{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [511:0] dig_pat(input int n);
    return {16{32'hD160_0000 + 32'(n)}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host memory monitor plus hash-core model, all sampled on the falling edge.
  initial begin : monitor
    int  blk_cnt, pending, dig_no;
    logic rd_af_prev, wr_af_prev;
    blk_cnt = 0; pending = 0; dig_no = 0;
    rd_af_prev = 1'b0; wr_af_prev = 1'b0;
    digest_valid = 1'b0;
    digest = '0;
    forever begin
      @(negedge clk);
      if (!reset_n || start) begin
        rd_addr_q.delete(); rd_tag_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); blk_q.delete();
        blk_cnt = 0; pending = 0; dig_no = 0;
        digest_valid = 1'b0;
      end else begin
        if (bus.rd_valid) begin
          rd_addr_q.push_back(bus.rd_addr);
          rd_tag_q.push_back(bus.rd_tag);
          if (bus.rd_almfull && rd_af_prev) rd_viol++;
          $display("rd  addr=%0h tag=%0d len=%0d", bus.rd_addr, bus.rd_tag, bus.rd_len);
        end
        if (bus.wr_valid) begin
          wr_addr_q.push_back(bus.wr_addr);
          wr_data_q.push_back(bus.wr_data);
          if (bus.wr_almfull && wr_af_prev) wr_viol++;
          $display("wr  addr=%0h data[31:0]=%0h", bus.wr_addr, bus.wr_data[31:0]);
        end
        if (block_valid && block_ready) begin
          blk_q.push_back(block);
          blk_cnt++;
          if (blk_cnt % LPD == 0) pending++;
        end
        if (digest_valid) begin
          digest_valid = 1'b0;
        end else if (pending > 0) begin
          dig_no++;
          digest = dig_pat(dig_no);
          digest_valid = 1'b1;
          pending--;
        end
      end
      rd_af_prev = bus.rd_almfull;
      wr_af_prev = bus.wr_almfull;
    end
  end

  task automatic serve(input logic [41:0] a, input logic [15:0] tag);
    for (int c = 0; c < CL; c++) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_tag   = tag;
      bus.rsp_clnum = 2'(c);
      bus.rsp_data  = line_pat(a + 42'(c));
      tick();
    end
    bus.rsp_valid = 1'b0;
  endtask

  task automatic start_job(input logic [41:0] s, input int lines,
                           input logic [41:0] d, input logic [41:0] m);
    served    = 0;
    src_addr  = s;
    src_lines = 32'(lines);
    dst_addr  = d;
    dsm_addr  = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Answers outstanding reads in issue order until the budget runs out.
  task automatic run_serve(input int budget, input bit stop_idle);
    int k = 0;
    while (k < budget && !(stop_idle && !busy)) begin
      if (served < rd_addr_q.size()) begin
        serve(rd_addr_q[served], rd_tag_q[served]);
        served++;
        k += CL;
      end else begin
        tick();
        k++;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("job_done_busy", 512'(busy), 512'(0));
    repeat (3) tick();
  endtask

  task automatic wait_reads(input int n, input int budget);
    int k = 0;
    while (rd_addr_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_reads", 512'(rd_addr_q.size() >= n), 512'(1));
  endtask

  task automatic check_job(input logic [41:0] s, input int lines,
                           input logic [41:0] d, input logic [41:0] m);
    int nr = lines / CL;
    chk("rd_count", 512'(rd_addr_q.size()), 512'(nr));
    if (rd_addr_q.size() == nr)
      for (int i = 0; i < nr; i++) begin
        chk($sformatf("rd_addr[%0d]", i), 512'(rd_addr_q[i]), 512'(s + 42'(i * CL)));
        chk($sformatf("rd_tag[%0d]", i), 512'(rd_tag_q[i]), 512'((i * CL) % BD));
      end
    chk("blk_count", 512'(blk_q.size()), 512'(lines));
    if (blk_q.size() == lines)
      for (int i = 0; i < lines; i++)
        chk($sformatf("blk[%0d]", i), blk_q[i], line_pat(s + 42'(i)));
    chk("wr_count", 512'(wr_addr_q.size()), 512'(2));
    if (wr_addr_q.size() == 2) begin
      chk("wr_digest_addr", 512'(wr_addr_q[0]), 512'(d));
      chk("wr_digest_data", wr_data_q[0], dig_pat(lines / LPD));
      chk("wr_dsm_addr", 512'(wr_addr_q[1]), 512'(m + 42'd1));
      chk("wr_dsm_data", wr_data_q[1], 512'd1);
    end
  endtask

  initial begin : stimulus
    logic [41:0] sv_addr [$];
    logic [15:0] sv_tag  [$];
    int n0;

    reset_n = 1'b0; start = 1'b0;
    src_addr = '0; src_lines = '0; dst_addr = '0; dsm_addr = '0;
    block_ready = 1'b1;
    bus.rd_almfull = 1'b0; bus.wr_almfull = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_tag = '0; bus.rsp_clnum = '0; bus.rsp_data = '0;
    repeat (3) tick();
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("reset_wr_valid", 512'(bus.wr_valid), 512'(0));
    chk("reset_block_valid", 512'(block_valid), 512'(0));
    chk("reset_block", block, 512'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // In-order responses, free-flowing output.
    start_job(42'h100, 8, 42'h900, 42'hA00);
    chk("run_busy", 512'(busy), 512'(1));
    run_serve(300, 1'b1);
    wait_idle(10);
    check_job(42'h100, 8, 42'h900, 42'hA00);

    // Responses returned in reverse tag order.
    start_job(42'h200, 8, 42'h910, 42'hA10);
    wait_reads(4, 40);
    repeat (3) tick();
    chk("rev_rd_count", 512'(rd_addr_q.size()), 512'(4));
    if (rd_addr_q.size() == 4) begin
      for (int i = 3; i >= 0; i--) serve(rd_addr_q[i], rd_tag_q[i]);
      served = 4;
    end
    run_serve(200, 1'b1);
    wait_idle(10);
    check_job(42'h200, 8, 42'h910, 42'hA10);

    // Output back-pressure fills the buffer and stalls issue.
    block_ready = 1'b0;
    start_job(42'h3F8, 16, 42'h920, 42'hA20);
    run_serve(40, 1'b0);
    chk("stall_rd_count", 512'(rd_addr_q.size()), 512'(4));
    chk("stall_block_valid", 512'(block_valid), 512'(1));
    chk("stall_block_held", block, line_pat(42'h3F8));
    chk("stall_blk_count", 512'(blk_q.size()), 512'(0));
    block_ready = 1'b1;
    run_serve(400, 1'b1);
    wait_idle(10);
    check_job(42'h3F8, 16, 42'h920, 42'hA20);

    // Almost-full on both request channels.
    bus.wr_almfull = 1'b1;
    start_job(42'h400, 16, 42'h930, 42'hA30);
    wait_reads(1, 20);
    bus.rd_almfull = 1'b1;
    n0 = rd_addr_q.size();
    repeat (10) tick();
    chk("rd_almfull_hold", 512'(rd_addr_q.size() <= n0 + 1), 512'(1));
    bus.rd_almfull = 1'b0;
    run_serve(200, 1'b0);
    chk("wr_almfull_hold_count", 512'(wr_addr_q.size()), 512'(0));
    chk("wr_almfull_hold_busy", 512'(busy), 512'(1));
    bus.wr_almfull = 1'b0;
    wait_idle(20);
    check_job(42'h400, 16, 42'h930, 42'hA30);
    chk("rd_almfull_violations", 512'(rd_viol), 512'(0));
    chk("wr_almfull_violations", 512'(wr_viol), 512'(0));

    // Length not a multiple of the request granule.
    start_job(42'h500, 3, 42'h940, 42'hA40);
    chk("err_busy", 512'(busy), 512'(1));
    wait_idle(20);
    chk("err_rd_count", 512'(rd_addr_q.size()), 512'(0));
    chk("err_wr_count", 512'(wr_addr_q.size()), 512'(1));
    if (wr_addr_q.size() == 1) begin
      chk("err_wr_addr", 512'(wr_addr_q[0]), 512'(42'hA41));
      chk("err_wr_data", wr_data_q[0], 512'd2);
    end

    // Reset in the middle of a job with reads outstanding.
    start_job(42'h600, 8, 42'h950, 42'hA50);
    wait_reads(3, 20);
    sv_addr = rd_addr_q;
    sv_tag  = rd_tag_q;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", 512'(busy), 512'(0));
    chk("mid_reset_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("mid_reset_rd_addr", 512'(bus.rd_addr), 512'(0));
    chk("mid_reset_rd_tag", 512'(bus.rd_tag), 512'(0));
    chk("mid_reset_wr_valid", 512'(bus.wr_valid), 512'(0));
    chk("mid_reset_wr_addr", 512'(bus.wr_addr), 512'(0));
    chk("mid_reset_wr_data", bus.wr_data, 512'd0);
    chk("mid_reset_block_valid", 512'(block_valid), 512'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < sv_addr.size(); i++) serve(sv_addr[i], sv_tag[i]);
    repeat (10) tick();
    chk("late_rsp_blocks", 512'(blk_q.size()), 512'(0));
    chk("late_rsp_block_valid", 512'(block_valid), 512'(0));
    chk("late_rsp_busy", 512'(busy), 512'(0));
    chk("late_rsp_reads", 512'(rd_addr_q.size()), 512'(0));

    start_job(42'h700, 8, 42'h960, 42'hA60);
    run_serve(300, 1'b1);
    wait_idle(10);
    check_job(42'h700, 8, 42'h960, 42'hA60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hash_requestor.md
HASH_REQUESTOR -- requirements
Module: hash_requestor

Interface
REQ-001 SHALL have parameter CL_PER_REQ, default 2, meaning cache lines per read request (1, 2 or 4).
REQ-002 SHALL have parameter BUF_DEPTH, default 8, meaning reorder-buffer slots of 512 bits each (power of 2, >= 2*CL_PER_REQ).
REQ-003 SHALL have parameter LINES_PER_DIGEST, default 2, meaning source lines consumed per digest_valid pulse.
REQ-004 SHALL have ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1 one-cycle job start; src_addr in 42 source line address; src_lines in 32 source length in lines; dst_addr in 42 digest line address; dsm_addr in 42 status line address.
REQ-006 SHALL have ports: rd_valid out 1; rd_addr out 42; rd_len out 2 (CL_PER_REQ-1); rd_tag out 16; rd_almfull in 1.
REQ-007 SHALL have ports: rsp_valid in 1; rsp_tag in 16; rsp_clnum in 2; rsp_data in 512.
REQ-008 SHALL have ports: block out 512; block_valid out 1; block_ready in 1; digest in 512; digest_valid in 1.
REQ-009 SHALL have ports: wr_valid out 1; wr_addr out 42; wr_data out 512; wr_almfull in 1; busy out 1.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> WR_DIGEST -> WR_DSM -> IDLE; busy=1 in every state except IDLE.
REQ-011 IDLE SHALL latch all job inputs on start=1 and clear every counter; start SHALL be ignored outside IDLE.
REQ-012 If src_lines==0 or src_lines is not a multiple of CL_PER_REQ*LINES_PER_DIGEST, start SHALL go directly to WR_DSM with status value 2 and issue no reads.
REQ-013 In RUN, a read SHALL issue (registered, rd_valid high one cycle) when rd_almfull=0, issued lines < src_lines and free slots >= CL_PER_REQ.
REQ-014 Free slots SHALL equal BUF_DEPTH minus (lines issued minus lines drained), using the updated counts for same-cycle issue and drain.
REQ-015 Read n SHALL have rd_addr = src_addr + n*CL_PER_REQ (42-bit wrap) and rd_tag = slot index of its first line, slots allocated contiguously modulo BUF_DEPTH.
REQ-016 A response SHALL write rsp_data to slot (rsp_tag + rsp_clnum) mod BUF_DEPTH and set that slot's valid bit; responses may arrive in any order.
REQ-017 Drain SHALL be strictly in order from head slot: block/block_valid are registered, and a new line is presented only when the head slot is valid and (block_valid=0 or block_ready=1).
REQ-018 block SHALL be held stable while block_valid=1 and block_ready=0; the slot valid bit is cleared when the line is loaded into the output register.
REQ-019 A same-cycle fill of one slot and drain of another SHALL both take effect.
REQ-020 Digest counter SHALL increment on each rising edge of digest_valid (0->1 transition only).
REQ-021 RUN SHALL exit to WR_DIGEST when all src_lines are drained and the digest count equals src_lines/LINES_PER_DIGEST, latching the last digest.
REQ-022 WR_DIGEST SHALL emit one write, wr_addr=dst_addr, wr_data=last digest, in the first cycle with wr_almfull=0, then go to WR_DSM.
REQ-023 WR_DSM SHALL emit one write, wr_addr=dsm_addr+1, wr_data=zero-extended status (1=ok, 2=error), when wr_almfull=0, then go to IDLE.
REQ-024 wr_valid and rd_valid SHALL each be high for exactly one cycle per transfer and never while the matching almfull input is high.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE and rd_valid, wr_valid, block_valid, busy, all slot valid bits and all counters to 0; block, rd_*, and wr_* data/address outputs to 0.
REQ-026 Reset mid-job SHALL abandon the job; responses arriving after reset release with no job active SHALL be dropped.

Verification
REQ-027 src_lines=8, CL_PER_REQ=2, in-order responses, block_ready=1, 4 digest pulses -> 4 reads at src_addr+0,2,4,6; 8 blocks in order; digest write to dst_addr; then dsm_addr+1 write of 1.
REQ-028 Same job, responses in reversed tag order -> blocks still emitted in source address order.
REQ-029 BUF_DEPTH=8, block_ready=0 -> exactly 4 reads (8 lines) issue, then stall; raising block_ready resumes issue.
REQ-030 rd_almfull=1 for 10 cycles mid-job, and wr_almfull=1 at WR_DIGEST -> no valid during almfull; each transfer occurs once after release.
REQ-031 src_lines=3 -> no reads; single write to dsm_addr+1 with data 2; busy returns 0.
REQ-032 reset_n pulsed low during RUN with 3 reads outstanding -> all outputs 0 immediately; late responses ignored; new start runs cleanly.
